mem_arbiter: RTL and testbench

- Sits upstream of the instruction fetch stage and the data memory stage, and muxes both onto a single byte-wide external memory port.
- Instruction port returns a full INST_WIDTH word, assembled from two consecutive byte reads.
- Data port does single-byte reads and writes.
- Per-port handshake is req/ready; ready is a one-cycle pulse, and read data is held stable until that port's next transaction.

---
 rtl/mem_arbiter_pkg.sv | 16 +
 rtl/mem_arbiter_pick.sv | 44 ++++
 rtl/mem_arbiter.sv | 158 +++++++++++++++
 tb/tb_mem_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared state and grant encodings for the mem_arbiter block.
// The optional round-robin arbitration is selected with MEM_ARBITER_RR_EN.
package mem_arbiter_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] I_LO  = 3'd1;
    localparam logic [STATE_W-1:0] I_HI  = 3'd2;
    localparam logic [STATE_W-1:0] D_ACC = 3'd3;
    localparam logic [STATE_W-1:0] DONE  = 3'd4;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

endpackage

// File: rtl/mem_arbiter_pick.sv
// Grant selection between instruction and data ports while the arbiter is idle.
// MEM_ARBITER_RR_EN: defined -> alternate on contention; undefined -> data always wins.
module mem_arbiter_pick
    import mem_arbiter_pkg::*;
(
`ifdef MEM_ARBITER_RR_EN
    input  logic clk,
    input  logic rst,
`endif
    input  logic i_req,
    input  logic d_req,
    input  logic idle,
    output logic grant_i,
    output logic grant_d
);

`ifdef MEM_ARBITER_RR_EN
    logic last_grant_q, last_grant_d;

    // On contention the port that did not win last time is served.
    always_comb begin
        grant_d      = idle && d_req && !(i_req && (last_grant_q == GRANT_D));
        grant_i      = idle && i_req && !grant_d;
        last_grant_d = last_grant_q;
        if (grant_d) begin
            last_grant_d = GRANT_D;
        end else if (grant_i) begin
            last_grant_d = GRANT_I;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= GRANT_D;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`else
    assign grant_d = idle && d_req;
    assign grant_i = idle && i_req && !d_req;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Muxes an instruction fetch port (two-byte reads) and a byte data port onto one memory port.
// Optional round-robin contention handling is enabled by MEM_ARBITER_RR_EN.
//
// Handshake: a client raises req and holds it until it sees its one-cycle ready pulse;
// once granted the transaction always completes, and read data stays stable until the
// same port's next capture. On the memory side mem_rd/mem_wr plus address and write data
// are held unchanged until mem_ack is sampled high on a rising edge.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int M_WIDTH    = 8,
    parameter int INST_WIDTH = 2 * M_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [M_WIDTH-1:0]    i_addr,
    output logic [INST_WIDTH-1:0] i_rdata,
    output logic                  i_ready,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [M_WIDTH-1:0]    d_addr,
    input  logic [M_WIDTH-1:0]    d_wdata,
    output logic [M_WIDTH-1:0]    d_rdata,
    output logic                  d_ready,
    output logic [M_WIDTH-1:0]    mem_addr,
    output logic [M_WIDTH-1:0]    mem_wdata,
    output logic                  mem_rd,
    output logic                  mem_wr,
    input  logic [M_WIDTH-1:0]    mem_rdata,
    input  logic                  mem_ack,
    output logic [STATE_W-1:0]    dbg_state
);

    logic [STATE_W-1:0]    state_q, state_d;
    logic [M_WIDTH-1:0]    mem_addr_q, mem_addr_d;
    logic [M_WIDTH-1:0]    mem_wdata_q, mem_wdata_d;
    logic [M_WIDTH-1:0]    d_rdata_q, d_rdata_d;
    logic [INST_WIDTH-1:0] i_rdata_q, i_rdata_d;
    logic                  mem_rd_q, mem_rd_d;
    logic                  mem_wr_q, mem_wr_d;
    logic                  i_ready_q, i_ready_d;
    logic                  d_ready_q, d_ready_d;
    logic                  grant_i, grant_d;

    mem_arbiter_pick u_pick (
`ifdef MEM_ARBITER_RR_EN
        .clk     (clk),
        .rst     (rst),
`endif
        .i_req   (i_req),
        .d_req   (d_req),
        .idle    (state_q == IDLE),
        .grant_i (grant_i),
        .grant_d (grant_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            d_rdata_q   <= '0;
            i_rdata_q   <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            i_ready_q   <= 1'b0;
            d_ready_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            d_rdata_q   <= d_rdata_d;
            i_rdata_q   <= i_rdata_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            i_ready_q   <= i_ready_d;
            d_ready_q   <= d_ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d = D_ACC;
                end else if (grant_i) begin
                    state_d = I_LO;
                end
            end
            I_LO:    if (mem_ack) state_d = I_HI;
            I_HI:    if (mem_ack) state_d = DONE;
            D_ACC:   if (mem_ack) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // Ready pulses default low: they are only raised on entry to DONE, which lasts one cycle.
    always_comb begin
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        d_rdata_d   = d_rdata_q;
        i_rdata_d   = i_rdata_q;
        mem_rd_d    = mem_rd_q;
        mem_wr_d    = mem_wr_q;
        i_ready_d   = 1'b0;
        d_ready_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    mem_wr_d    = d_we;
                    mem_rd_d    = !d_we;
                end else if (grant_i) begin
                    mem_addr_d = i_addr;
                    mem_rd_d   = 1'b1;
                end
            end
            I_LO: begin
                if (mem_ack) begin
                    i_rdata_d[M_WIDTH-1:0] = mem_rdata;
                    mem_addr_d             = mem_addr_q + M_WIDTH'(1);
                end
            end
            I_HI: begin
                if (mem_ack) begin
                    i_rdata_d[INST_WIDTH-1:M_WIDTH] = mem_rdata;
                    mem_rd_d                        = 1'b0;
                    i_ready_d                       = 1'b1;
                end
            end
            D_ACC: begin
                if (mem_ack) begin
                    if (mem_rd_q) begin
                        d_rdata_d = mem_rdata;
                    end
                    mem_rd_d  = 1'b0;
                    mem_wr_d  = 1'b0;
                    d_ready_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;
    assign i_rdata   = i_rdata_q;
    assign i_ready   = i_ready_q;
    assign d_rdata   = d_rdata_q;
    assign d_ready   = d_ready_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed steps plus random transactions against a transaction-level model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int MW = 8;
  localparam int IW = 16;

  // ---------------- clock / reset / DUT signals ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [MW-1:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  logic [IW-1:0] i_rdata;
  logic i_ready, d_ready;
  logic [MW-1:0] d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic mem_rd, mem_wr, mem_ack;
  logic [STATE_W-1:0] dbg_state;

  always #5 clk = ~clk;

  mem_arbiter #(.M_WIDTH(MW), .INST_WIDTH(IW)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .dbg_state(dbg_state)
  );

  // ---------------- memory model: registered ack, mem_waits extra cycles per byte ----------------
  logic [MW-1:0] mem [256];
  int mem_waits = 0;
  int mem_cnt = 0;
  logic ack_r = 1'b0;

  assign mem_ack   = ack_r;
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_r <= 1'b0;
      mem_cnt <= 0;
    end else if (!(mem_rd || mem_wr)) begin
      ack_r <= 1'b0;
      mem_cnt <= 0;
    end else if (ack_r) begin
      if (mem_wr) mem[mem_addr] <= mem_wdata;
      mem_cnt <= 1;
      ack_r <= (mem_waits == 0);
    end else if (mem_cnt >= mem_waits) begin
      ack_r <= 1'b1;
    end else begin
      mem_cnt <= mem_cnt + 1;
    end
  end

  // ---------------- bus monitor ----------------
  logic [17:0] acc_log [$];
  int rd_starts = 0, unstable_hits = 0, both_hits = 0;
  logic prev_strobe = 1'b0, prev_ack = 1'b0, prev_rd = 1'b0;
  logic [17:0] prev_bus = '0;

  always @(negedge clk) begin
    if (rst) begin
      prev_strobe = 1'b0;
      prev_rd = 1'b0;
    end else begin
      if (mem_rd && mem_wr) both_hits++;
      if (prev_strobe && !prev_ack && ({mem_rd, mem_wr, mem_addr, mem_wdata} !== prev_bus))
        unstable_hits++;
      if (mem_rd && !prev_rd) rd_starts++;
      if ((mem_rd || mem_wr) && mem_ack)
        acc_log.push_back({mem_rd, mem_wr, (mem_wr ? mem_wdata : 8'h00), mem_addr});
      prev_strobe = mem_rd || mem_wr;
      prev_ack = mem_ack;
      prev_rd = mem_rd;
      prev_bus = {mem_rd, mem_wr, mem_addr, mem_wdata};
    end
  end

  // ---------------- reference model and scoreboard ----------------
  logic [MW-1:0] ref_mem [256];
  logic [IW-1:0] i_rdata_m = '0;
  logic [MW-1:0] d_rdata_m = '0;
  logic last_grant_m = GRANT_D;
  logic [IW-1:0] exp_q [$];
  int n_tests = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [MW-1:0] a, input logic [MW-1:0] v);
    mem[a] = v;
    ref_mem[a] = v;
  endtask

  // Waits for a ready pulse; cyc counts cycles after the edge that sampled req.
  task automatic wait_ready(input bit is_i, output int cyc);
    cyc = -1;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(is_i ? i_ready : d_ready) && cyc < 200);
  endtask

  // ---------------- driver tasks ----------------
  task automatic inst_txn(input logic [MW-1:0] a, input int w, input string tag);
    int cyc, starts0;
    logic [MW-1:0] a1;
    a1 = a + 8'd1;
    mem_waits = w;
    exp_q.push_back({ref_mem[a1], ref_mem[a]});
    acc_log.delete();
    starts0 = rd_starts;
    @(negedge clk);
    i_req = 1'b1;
    i_addr = a;
    wait_ready(1'b1, cyc);
    check({tag, " i_ready"}, 32'(i_ready), 32'd1);
    check({tag, " latency"}, cyc, 2 * w + 3);
    i_rdata_m = exp_q.pop_front();
    check({tag, " i_rdata"}, 32'(i_rdata), 32'(i_rdata_m));
    @(negedge clk);
    i_req = 1'b0;
    @(negedge clk);
    check({tag, " one grant"}, rd_starts - starts0, 1);
    check({tag, " no regrant"}, {dbg_state, mem_rd}, {IDLE, 1'b0});
    check({tag, " access count"}, acc_log.size(), 2);
    if (acc_log.size() == 2)
      check({tag, " addr seq"}, {acc_log[0], acc_log[1]}, {2'b10, 8'h00, a, 2'b10, 8'h00, a1});
    check({tag, " d_rdata kept"}, 32'(d_rdata), 32'(d_rdata_m));
    last_grant_m = GRANT_I;
  endtask

  task automatic data_txn(input bit we, input logic [MW-1:0] a, input logic [MW-1:0] wd,
                          input int w, input string tag);
    int cyc, starts0;
    mem_waits = w;
    if (we) ref_mem[a] = wd;
    else exp_q.push_back(IW'(ref_mem[a]));
    acc_log.delete();
    starts0 = rd_starts;
    @(negedge clk);
    d_req = 1'b1;
    d_we = we;
    d_addr = a;
    d_wdata = wd;
    wait_ready(1'b0, cyc);
    check({tag, " d_ready"}, 32'(d_ready), 32'd1);
    check({tag, " latency"}, cyc, w + 2);
    if (!we) d_rdata_m = exp_q.pop_front()[MW-1:0];
    check({tag, " d_rdata"}, 32'(d_rdata), 32'(d_rdata_m));
    @(negedge clk);
    d_req = 1'b0;
    @(negedge clk);
    check({tag, " one grant"}, rd_starts - starts0, we ? 0 : 1);
    check({tag, " idle after"}, {dbg_state, mem_rd, mem_wr}, {IDLE, 2'b00});
    check({tag, " access"}, acc_log.size() == 1 ? 32'(acc_log[0]) : 32'hFFFF_FFFF,
          32'({!we, we, (we ? wd : 8'h00), a}));
    check({tag, " i_rdata kept"}, 32'(i_rdata), 32'(i_rdata_m));
    last_grant_m = GRANT_D;
  endtask

  task automatic contend(input logic [MW-1:0] ia, input logic [MW-1:0] da, input string tag);
    logic exp_first_d, first_d;
    bit got_i, got_d, drop_i, drop_d;
    int n, starts0;
    logic [IW-1:0] ei;
    logic [MW-1:0] ed, ia1;
`ifdef MEM_ARBITER_RR_EN
    exp_first_d = (last_grant_m == GRANT_I);
`else
    exp_first_d = 1'b1;
`endif
    ia1 = ia + 8'd1;
    ei = {ref_mem[ia1], ref_mem[ia]};
    ed = ref_mem[da];
    mem_waits = $urandom_range(0, 1);
    first_d = 1'bx;
    got_i = 0; got_d = 0; drop_i = 0; drop_d = 0; n = 0;
    starts0 = rd_starts;
    @(negedge clk);
    i_req = 1'b1; i_addr = ia;
    d_req = 1'b1; d_we = 1'b0; d_addr = da;
    while (!(got_i && got_d) && n < 300) begin
      @(negedge clk);
      n++;
      if (drop_i) begin i_req = 1'b0; drop_i = 0; end
      if (drop_d) begin d_req = 1'b0; drop_d = 0; end
      if (i_ready && !got_i) begin got_i = 1; drop_i = 1; if (!got_d) first_d = 1'b0; end
      if (d_ready && !got_d) begin got_d = 1; drop_d = 1; if (!got_i) first_d = 1'b1; end
    end
    @(negedge clk);
    i_req = 1'b0;
    d_req = 1'b0;
    check({tag, " both served"}, {got_i, got_d}, 2'b11);
    check({tag, " data first"}, 32'(first_d), 32'(exp_first_d));
    check({tag, " i_rdata"}, 32'(i_rdata), 32'(ei));
    check({tag, " d_rdata"}, 32'(d_rdata), 32'(ed));
    @(negedge clk);
    check({tag, " two grants"}, rd_starts - starts0, 2);
    check({tag, " idle after"}, {dbg_state, mem_rd}, {IDLE, 1'b0});
    i_rdata_m = ei;
    d_rdata_m = ed;
    last_grant_m = first_d ? GRANT_I : GRANT_D;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

  // ---------------- directed and random sequence ----------------
  initial begin
    int n;
    for (int i = 0; i < 256; i++) poke(8'(i), 8'($urandom_range(0, 255)));
    poke(8'h10, 8'h34);
    poke(8'h11, 8'h12);
    poke(8'hFF, 8'hCD);
    poke(8'h00, 8'hAB);

    // reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset outputs", {i_rdata, i_ready, d_rdata, d_ready, mem_addr, mem_wdata, mem_rd, mem_wr},
          '0);
    check("reset state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b0;

    // instruction read, zero-wait and wrap with wait states
    inst_txn(8'h10, 0, "inst zero-wait");
    check("inst 0x10 value", 32'(i_rdata), 32'h1234);
    inst_txn(8'hFF, 2, "inst wrap");
    check("inst wrap value", 32'(i_rdata), 32'hABCD);

    // data write then read back
    data_txn(1'b1, 8'h40, 8'h5A, 0, "data write");
    data_txn(1'b0, 8'h40, 8'h00, 0, "data read");
    check("data 0x40 value", 32'(d_rdata), 32'h5A);
    check("inst after data", 32'(i_rdata), 32'hABCD);

    // contention after a data grant
    data_txn(1'b0, 8'h41, 8'h00, 1, "pre-contend read");
    contend(8'h10, 8'h40, "contend");

    // reset while waiting on the high byte
    mem_waits = 5;
    @(negedge clk);
    i_req = 1'b1;
    i_addr = 8'h20;
    n = 0;
    while (!(mem_rd && mem_addr == 8'h21) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("rst reach I_HI", 32'(dbg_state), 32'(I_HI));
    rst = 1'b1;
    #1;
    check("rst mid abort", {mem_rd, i_ready, i_rdata, dbg_state}, '0);
    i_req = 1'b0;
    i_rdata_m = '0;
    d_rdata_m = '0;
    last_grant_m = GRANT_D;
    @(negedge clk);
    check("rst no ready", {i_ready, d_ready}, 2'b00);
    rst = 1'b0;
    inst_txn(8'h30, 0, "after reset");

    // randomized traffic
    for (int k = 0; k < 24; k++) begin
      case ($urandom_range(0, 3))
        0: inst_txn(8'($urandom_range(0, 255)), $urandom_range(0, 2), "rnd inst");
        1: data_txn(1'b1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                    $urandom_range(0, 2), "rnd write");
        2: data_txn(1'b0, 8'($urandom_range(0, 255)), 8'h00, $urandom_range(0, 2), "rnd read");
        default: contend(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), "rnd contend");
      endcase
    end

    check("strobes stable in waits", unstable_hits, 0);
    check("rd and wr exclusive", both_hits, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
